// File: rtl/uart_pkg.sv
// Shared types and constants for the sample-to-UART serializer: FSM states,
// byte and frame sizes, and the frame byte-order helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int BITS_PER_BYTE   = 8;
  localparam int FRAME_BYTES_HDR = 3;
  localparam int FRAME_BYTES_RAW = 2;

  // Byte at position idx within a frame: [header,] sample MSB, sample LSB.
  function automatic logic [7:0] frame_byte(input logic [15:0] sample,
                                            input logic [1:0]  idx,
                                            input logic        hdr_en,
                                            input logic [7:0]  hdr);
    logic [7:0] b;
    if (hdr_en) begin
      case (idx)
        2'd0:    b = hdr;
        2'd1:    b = sample[15:8];
        default: b = sample[7:0];
      endcase
    end else begin
      b = (idx == 2'd0) ? sample[15:8] : sample[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 byte serializer: tx_o goes low on the byte_start edge, 10*CLKS_PER_BIT cycles per byte.
// byte_done_o marks the last stop-bit cycle; a byte_start there chains the next start bit with no gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 18
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       byte_start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_last_clk, w_done;

  assign w_last_clk = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (byte_start_i) begin
          w_state_nxt = ST_START;
          w_shift_nxt = byte_i;
        end
      end
      ST_START: begin
        if (w_last_clk) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_last_clk) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'(BITS_PER_BYTE - 1)) w_state_nxt = ST_STOP;
          else                                w_bit_nxt   = r_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_last_clk) begin
          w_done    = 1'b1;
          w_cnt_nxt = '0;
          if (byte_start_i) begin
            w_state_nxt = ST_START;
            w_shift_nxt = byte_i;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Line level follows the state being entered so tx_o stays a pure register.
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign tx_o        = r_tx;
  assign byte_done_o = w_done;

endmodule

// File: rtl/uart_sample_tx.sv
// Frames each accepted 16-bit sample as [HEADER,] MSB, LSB over 8N1; start bit begins on the accept edge.
// Ready only while idle, so upstream stalls for the whole frame plus one cycle.
module uart_sample_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 18,
  parameter bit         HEADER_EN    = 1'b1,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [1:0] LAST_IDX = HEADER_EN ? 2'(FRAME_BYTES_HDR - 1)
                                              : 2'(FRAME_BYTES_RAW - 1);

  logic [15:0] r_sample;
  logic [1:0]  r_byte_idx;
  logic        r_ready, r_busy;
  logic        w_accept, w_byte_done, w_last_byte, w_byte_start;
  logic [7:0]  w_byte;

  assign w_accept     = sample_valid_i & r_ready;
  assign w_last_byte  = (r_byte_idx == LAST_IDX);
  assign w_byte_start = w_accept | (w_byte_done & r_busy & ~w_last_byte);

  // The first byte is fetched straight from sample_i since r_sample loads on the same edge.
  assign w_byte = w_accept ? frame_byte(sample_i, 2'd0, HEADER_EN, HEADER)
                           : frame_byte(r_sample, r_byte_idx + 2'd1, HEADER_EN, HEADER);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sample   <= '0;
      r_byte_idx <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      r_sample   <= sample_i;
      r_byte_idx <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
    end else if (r_busy) begin
      if (w_byte_done) begin
        if (w_last_byte) begin
          r_busy     <= 1'b0;
          r_ready    <= 1'b1;
          r_byte_idx <= '0;
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end else begin
      r_ready <= 1'b1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .byte_start_i(w_byte_start),
    .byte_i      (w_byte),
    .tx_o        (tx_o),
    .byte_done_o (w_byte_done)
  );

  assign sample_ready_o = r_ready;
  assign busy_o         = r_busy;
  assign frame_done_o   = w_byte_done & w_last_byte & r_busy;

endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed bench: three instances (CLKS_PER_BIT=4 with/without header, defaults),
// tx_o traced per cycle and decoded against hand-computed frames.
module tb_uart_sample_tx;

  localparam int TRN = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  vld, rdy, txl, bsy, dn;
  logic [15:0] smp [3];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        tr  [3][TRN];
  logic        dtr [3][TRN];

  always #5 clk = ~clk;

  uart_sample_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1'b1), .HEADER(8'hA5)) u_hdr (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(smp[0]), .sample_valid_i(vld[0]),
    .sample_ready_o(rdy[0]), .tx_o(txl[0]), .busy_o(bsy[0]), .frame_done_o(dn[0]));

  uart_sample_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1'b0), .HEADER(8'hA5)) u_raw (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(smp[1]), .sample_valid_i(vld[1]),
    .sample_ready_o(rdy[1]), .tx_o(txl[1]), .busy_o(bsy[1]), .frame_done_o(dn[1]));

  uart_sample_tx u_def (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(smp[2]), .sample_valid_i(vld[2]),
    .sample_ready_o(rdy[2]), .tx_o(txl[2]), .busy_o(bsy[2]), .frame_done_o(dn[2]));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < TRN) begin
      for (int k = 0; k < 3; k++) begin
        tr[k][cyc]  = txl[k];
        dtr[k][cyc] = dn[k];
      end
    end
  endtask

  function automatic logic lvl_exp(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Cycles in the traced frame whose level differs from an ideal 8N1 waveform.
  function automatic int frame_errs(input int k, input int s, input int nb,
                                    input logic [23:0] bytes, input int cpb);
    int e = 0;
    int idx;
    logic [7:0] b;
    if (s < 0) return -1;
    for (int i = 0; i < nb; i++) begin
      b = bytes[23-8*i -: 8];
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < cpb; c++) begin
          idx = s + (i*10 + j)*cpb + c;
          if (idx >= TRN || tr[k][idx] !== lvl_exp(b, j)) e++;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] dec_byte(input int k, input int s, input int bi, input int cpb);
    logic [7:0] b = 'x;
    int idx;
    if (s < 0) return b;
    for (int j = 0; j < 8; j++) begin
      idx = s + (bi*10 + 1 + j)*cpb + cpb/2;
      b[j] = (idx < TRN) ? tr[k][idx] : 1'bx;
    end
    return b;
  endfunction

  function automatic int count_pulses(input int k, input int a, input int b);
    int n = 0;
    if (a < 0) return -1;
    for (int i = a; i <= b && i < TRN; i++) if (dtr[k][i] === 1'b1) n++;
    return n;
  endfunction

  task automatic send_frame(input int k, input logic [15:0] data, input int lim,
                            output int s, output int d);
    s = -1;
    d = -1;
    smp[k] = data;
    vld[k] = 1'b1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      step();
      if (bsy[k]) s = cyc;
    end
    vld[k] = 1'b0;
    if (s >= 0) begin
      for (int i = 0; i < lim && d < 0; i++) begin
        step();
        if (dn[k]) d = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld   = 3'b000;
    for (int k = 0; k < 3; k++) smp[k] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if ({txl, rdy, bsy, dn} !== {3'b111, 9'b0}) begin
        n_err++;
        $display("FAIL reset_hold: cycle %0d got tx=%b rdy=%b busy=%b done=%b, want tx=111 rdy=000 busy=000 done=000",
                 i, txl, rdy, bsy, dn);
      end
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({txl, rdy, bsy} !== {3'b111, 3'b111, 3'b000}) begin
      n_err++;
      $display("FAIL reset_release: got tx=%b rdy=%b busy=%b, want tx=111 rdy=111 busy=000", txl, rdy, bsy);
    end
  endtask

  task automatic test_single();
    int s, d;
    logic [23:0] got;
    send_frame(0, 16'h1234, 200, s, d);
    n_vec++;
    if (s < 0 || d !== s + 119) begin
      n_err++;
      $display("FAIL single_len: start=%0d done=%0d, want done at start+119", s, d);
    end
    n_vec++;
    if (bsy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_at_done: got %b want 1", bsy[0]);
    end
    step();
    n_vec++;
    if ({rdy[0], bsy[0], txl[0]} !== 3'b101) begin
      n_err++;
      $display("FAIL single_ready_return: got rdy=%b busy=%b tx=%b, want 1 0 1", rdy[0], bsy[0], txl[0]);
    end
    got = {dec_byte(0, s, 0, 4), dec_byte(0, s, 1, 4), dec_byte(0, s, 2, 4)};
    n_vec++;
    if (got !== 24'hA51234) begin
      n_err++;
      $display("FAIL single_bytes: got %h want a51234", got);
    end
    n_vec++;
    if (frame_errs(0, s, 3, 24'hA51234, 4) !== 0) begin
      n_err++;
      $display("FAIL single_wave: got %0d bad cycles want 0", frame_errs(0, s, 3, 24'hA51234, 4));
    end
    n_vec++;
    if (count_pulses(0, s, cyc) !== 1) begin
      n_err++;
      $display("FAIL single_done_pulses: got %0d want 1", count_pulses(0, s, cyc));
    end
  endtask

  task automatic test_no_header();
    int s, d;
    logic [15:0] got;
    send_frame(1, 16'hBEEF, 200, s, d);
    n_vec++;
    if (s < 0 || d !== s + 79) begin
      n_err++;
      $display("FAIL nohdr_len: start=%0d done=%0d, want done at start+79", s, d);
    end
    got = {dec_byte(1, s, 0, 4), dec_byte(1, s, 1, 4)};
    n_vec++;
    if (got !== 16'hBEEF) begin
      n_err++;
      $display("FAIL nohdr_bytes: got %h want beef", got);
    end
    n_vec++;
    if (frame_errs(1, s, 2, 24'hBEEF00, 4) !== 0) begin
      n_err++;
      $display("FAIL nohdr_wave: got %0d bad cycles want 0", frame_errs(1, s, 2, 24'hBEEF00, 4));
    end
    step();
    n_vec++;
    if ({rdy[1], txl[1]} !== 2'b11) begin
      n_err++;
      $display("FAIL nohdr_idle: got rdy=%b tx=%b want 1 1", rdy[1], txl[1]);
    end
  endtask

  task automatic test_back_to_back();
    int s1 = -1, d1 = -1, s2 = -1, d2 = -1;
    logic [23:0] f1, f2;
    smp[0] = 16'h0001;
    vld[0] = 1'b1;
    for (int i = 0; i < 20 && s1 < 0; i++) begin
      step();
      if (bsy[0]) s1 = cyc;
    end
    smp[0] = 16'hFFFF;
    for (int i = 0; i < 200 && d1 < 0; i++) begin
      step();
      if (dn[0]) d1 = cyc;
    end
    for (int i = 0; i < 10 && s2 < 0; i++) begin
      step();
      if (bsy[0]) s2 = cyc;
    end
    vld[0] = 1'b0;
    for (int i = 0; i < 200 && d2 < 0; i++) begin
      step();
      if (dn[0]) d2 = cyc;
    end
    n_vec++;
    if (d1 < 0 || s2 !== d1 + 2) begin
      n_err++;
      $display("FAIL b2b_accept_spacing: done1=%0d start2=%0d, want start2=done1+2", d1, s2);
    end
    n_vec++;
    if (d1 < 0 || tr[0][d1+1] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_gap_level: got %b want 1", (d1 < 0) ? 1'bx : tr[0][d1+1]);
    end
    f1 = {dec_byte(0, s1, 0, 4), dec_byte(0, s1, 1, 4), dec_byte(0, s1, 2, 4)};
    f2 = {dec_byte(0, s2, 0, 4), dec_byte(0, s2, 1, 4), dec_byte(0, s2, 2, 4)};
    n_vec++;
    if ({f1, f2} !== 48'hA50001_A5FFFF) begin
      n_err++;
      $display("FAIL b2b_bytes: got %h %h want a50001 a5ffff", f1, f2);
    end
    n_vec++;
    if (frame_errs(0, s1, 3, 24'hA50001, 4) !== 0 || frame_errs(0, s2, 3, 24'hA5FFFF, 4) !== 0) begin
      n_err++;
      $display("FAIL b2b_wave: got %0d/%0d bad cycles want 0/0",
               frame_errs(0, s1, 3, 24'hA50001, 4), frame_errs(0, s2, 3, 24'hA5FFFF, 4));
    end
    n_vec++;
    if (s2 < 0 || d2 !== s2 + 119) begin
      n_err++;
      $display("FAIL b2b_len2: start=%0d done=%0d, want done at start+119", s2, d2);
    end
    step();
  endtask

  task automatic test_busy_immunity();
    int s = -1, d = -1;
    logic [23:0] got;
    smp[0] = 16'h00FF;
    vld[0] = 1'b1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      step();
      if (bsy[0]) s = cyc;
    end
    for (int i = 0; i < 200 && s >= 0 && d < 0; i++) begin
      smp[0] = 16'($urandom);
      vld[0] = 1'($urandom);
      step();
      if (dn[0]) d = cyc;
    end
    vld[0] = 1'b0;
    smp[0] = 16'h0000;
    got = {dec_byte(0, s, 0, 4), dec_byte(0, s, 1, 4), dec_byte(0, s, 2, 4)};
    n_vec++;
    if (got !== 24'hA500FF) begin
      n_err++;
      $display("FAIL busy_imm_bytes: got %h want a500ff", got);
    end
    n_vec++;
    if (frame_errs(0, s, 3, 24'hA500FF, 4) !== 0 || s < 0 || d !== s + 119) begin
      n_err++;
      $display("FAIL busy_imm_wave: bad=%0d start=%0d done=%0d, want 0 bad and done at start+119",
               frame_errs(0, s, 3, 24'hA500FF, 4), s, d);
    end
    step();
    step();
    n_vec++;
    if ({bsy[0], rdy[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL busy_imm_after: got busy=%b rdy=%b want 0 1", bsy[0], rdy[0]);
    end
  endtask

  task automatic test_mid_reset();
    int s = -1, s2, d2;
    logic [23:0] got;
    smp[0] = 16'h1234;
    vld[0] = 1'b1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      step();
      if (bsy[0]) s = cyc;
    end
    vld[0] = 1'b0;
    for (int i = 0; i < 100 && s >= 0 && cyc < s + 85; i++) step();
    n_vec++;
    if (txl[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_pre_level: got tx=%b want 0 (LSB byte data bit 0)", txl[0]);
    end
    rst_n = 1'b0;
    step();
    n_vec++;
    if ({txl[0], bsy[0], rdy[0], dn[0]} !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_abort: got tx=%b busy=%b rdy=%b done=%b want 1 0 0 0",
               txl[0], bsy[0], rdy[0], dn[0]);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({rdy[0], txl[0]} !== 2'b11 || count_pulses(0, s, cyc) !== 0) begin
      n_err++;
      $display("FAIL midrst_release: got rdy=%b tx=%b pulses=%0d want 1 1 0",
               rdy[0], txl[0], count_pulses(0, s, cyc));
    end
    send_frame(0, 16'h5A5A, 200, s2, d2);
    got = {dec_byte(0, s2, 0, 4), dec_byte(0, s2, 1, 4), dec_byte(0, s2, 2, 4)};
    n_vec++;
    if (got !== 24'hA55A5A || frame_errs(0, s2, 3, 24'hA55A5A, 4) !== 0) begin
      n_err++;
      $display("FAIL midrst_next_frame: got %h bad=%0d want a55a5a bad=0",
               got, frame_errs(0, s2, 3, 24'hA55A5A, 4));
    end
    n_vec++;
    if (s2 < 0 || d2 !== s2 + 119) begin
      n_err++;
      $display("FAIL midrst_next_len: start=%0d done=%0d, want done at start+119", s2, d2);
    end
    step();
  endtask

  task automatic test_defaults();
    int s, d;
    logic [23:0] got;
    send_frame(2, 16'h8001, 700, s, d);
    n_vec++;
    if (s < 0 || d !== s + 539) begin
      n_err++;
      $display("FAIL def_len: start=%0d done=%0d, want done at start+539", s, d);
    end
    got = {dec_byte(2, s, 0, 18), dec_byte(2, s, 1, 18), dec_byte(2, s, 2, 18)};
    n_vec++;
    if (got !== 24'hA58001) begin
      n_err++;
      $display("FAIL def_bytes: got %h want a58001", got);
    end
    n_vec++;
    if (frame_errs(2, s, 3, 24'hA58001, 18) !== 0) begin
      n_err++;
      $display("FAIL def_wave: got %0d bad cycles want 0", frame_errs(2, s, 3, 24'hA58001, 18));
    end
    step();
    n_vec++;
    if ({rdy[2], bsy[2]} !== 2'b10 || count_pulses(2, s, cyc) !== 1) begin
      n_err++;
      $display("FAIL def_end: got rdy=%b busy=%b pulses=%0d want 1 0 1",
               rdy[2], bsy[2], count_pulses(2, s, cyc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_no_header();
    test_back_to_back();
    test_busy_immunity();
    test_mid_reset();
    test_defaults();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
